// File: rtl/dp_sequencer.sv
// dp_sequencer: boot/run/halt sequencing and instruction decode for the 16-bit datapath.
// Define DP_SEQ_STEP_EN to enable the haltReq/stepReq debug run-control ports.

module dp_sequencer #(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       instIn,
    input  logic [7:0]       funcIn,
    output logic             pcLd,
    output logic             rstPC,
    output logic             pcSel,
    output logic             jumpSel,
    output logic             branchSel,
    output logic             regSel,
    output logic             regJsel,
    output logic             selRj,
    output logic             inSel,
    output logic             selALU,
    output logic             selDm,
    output logic             regWrite,
    output logic             nop,
    output logic             memRead,
    output logic             memWrite,
    output logic             ldWnd,
    output logic [1:0]       wndCtrl,
    output logic [2:0]       funcCtrl,
    input  logic             haltReq,
    input  logic             stepReq,
    output logic             stepAck,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] boot_cnt;
    logic          boot_done;
    logic          is_halt_op;
    logic          exec;
    logic          exec_illegal;
    logic          step_exec;
    logic          halt_hold;
    logic          halt_release;

    assign boot_done  = (boot_cnt == BW'(BOOT_CYCLES - 1));
    assign is_halt_op = (instIn == 4'b1111);
    assign exec       = (state == RUN) || step_exec;

`ifdef DP_SEQ_STEP_EN
    logic step_prev;
    logic step_accept;

    assign halt_hold    = haltReq;
    assign halt_release = ~haltReq;
    // Edges arriving while a step is executing or being acknowledged are dropped.
    assign step_accept  = (state == HALT) && haltReq && stepReq && !step_prev
                          && !step_exec && !stepAck;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_prev <= 1'b0;
            step_exec <= 1'b0;
            stepAck   <= 1'b0;
        end else begin
            step_prev <= stepReq;
            step_exec <= step_accept;
            stepAck   <= step_exec;
        end
    end
`else
    logic unused_debug;

    assign unused_debug = haltReq ^ stepReq;
    assign halt_hold    = 1'b0;
    assign halt_release = 1'b0;
    assign step_exec    = 1'b0;
    assign stepAck      = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    if (boot_done) state_next = RUN;
            RUN:     if (is_halt_op || halt_hold) state_next = HALT;
            HALT:    if (!(step_exec && is_halt_op) && halt_release) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        pcLd         = 1'b0;
        rstPC        = 1'b0;
        pcSel        = 1'b0;
        jumpSel      = 1'b0;
        branchSel    = 1'b0;
        regSel       = 1'b0;
        regJsel      = 1'b0;
        selRj        = 1'b0;
        inSel        = 1'b0;
        selALU       = 1'b0;
        selDm        = 1'b0;
        regWrite     = 1'b0;
        nop          = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        ldWnd        = 1'b0;
        wndCtrl      = 2'b00;
        funcCtrl     = 3'b000;
        exec_illegal = 1'b0;
        if (state == BOOT) begin
            rstPC = 1'b1;
            pcLd  = 1'b1;
        end else if (exec) begin
            pcLd  = 1'b1;
            pcSel = 1'b1;
            nop   = 1'b1;
            case (instIn)
                4'b0000: begin
                    memRead  = 1'b1;
                    selDm    = 1'b1;
                    regWrite = 1'b1;
                end
                4'b0001: memWrite = 1'b1;
                4'b0010: begin
                    jumpSel = 1'b1;
                    pcSel   = 1'b0;
                end
                4'b0100: begin
                    branchSel = 1'b1;
                    regSel    = 1'b1;
                    selRj     = 1'b1;
                    funcCtrl  = 3'b001;
                end
                4'b1000: begin
                    selALU   = 1'b1;
                    regWrite = 1'b1;
                    case (funcIn)
                        8'h01: begin regJsel = 1'b1; funcCtrl = 3'b101; end
                        8'h02: begin regSel = 1'b1; selRj = 1'b1; funcCtrl = 3'b000; end
                        8'h04: begin regSel = 1'b1; selRj = 1'b1; funcCtrl = 3'b001; end
                        8'h08: begin regSel = 1'b1; selRj = 1'b1; funcCtrl = 3'b010; end
                        8'h10: begin regSel = 1'b1; selRj = 1'b1; funcCtrl = 3'b011; end
                        8'h20: begin regJsel = 1'b1; funcCtrl = 3'b100; end
                        8'h40: begin
                            selALU   = 1'b0;
                            regWrite = 1'b0;
                            nop      = 1'b0;
                        end
                        default: begin
                            selALU       = 1'b0;
                            regWrite     = 1'b0;
                            nop          = 1'b0;
                            exec_illegal = 1'b1;
                        end
                    endcase
                end
                4'b1001: begin
                    ldWnd   = 1'b1;
                    wndCtrl = funcIn[1:0];
                end
                // ADDI/SUBI/ANDI map their low opcode bits straight onto ADD/SUB/AND.
                4'b1100, 4'b1101, 4'b1110: begin
                    regSel   = 1'b1;
                    inSel    = 1'b1;
                    selALU   = 1'b1;
                    regWrite = 1'b1;
                    funcCtrl = {1'b0, instIn[1:0]};
                end
                4'b1111: ;
                default: begin
                    nop          = 1'b0;
                    exec_illegal = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            boot_cnt <= '0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            retired  <= '0;
        end else begin
            state  <= state_next;
            halted <= (state_next == HALT);
            if (state == BOOT && !boot_done)
                boot_cnt <= boot_cnt + BW'(1);
            if (exec_illegal)
                illegal <= 1'b1;
            if (exec)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: directed run-control cases plus randomized decode
// against a cycle-level reference model. Honours DP_SEQ_STEP_EN when defined.

module tb_dp_sequencer;

    localparam int BOOT_CYCLES = 2;
    localparam int CNT_W       = 16;
`ifdef DP_SEQ_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pcLd, rstPC, pcSel, jumpSel, branchSel, regSel, regJsel, selRj;
        logic       inSel, selALU, selDm, regWrite, nop, memRead, memWrite, ldWnd;
        logic [1:0] wndCtrl;
        logic [2:0] funcCtrl;
    } ctrl_t;

    logic             clk, rst;
    logic [3:0]       instIn;
    logic [7:0]       funcIn;
    logic             pcLd, rstPC, pcSel, jumpSel, branchSel, regSel, regJsel, selRj;
    logic             inSel, selALU, selDm, regWrite, nop, memRead, memWrite, ldWnd;
    logic [1:0]       wndCtrl;
    logic [2:0]       funcCtrl;
    logic             haltReq, stepReq, stepAck, halted, illegal;
    logic [CNT_W-1:0] retired;
    ctrl_t            obsCtrl;

    dp_sequencer #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instIn(instIn), .funcIn(funcIn),
        .pcLd(pcLd), .rstPC(rstPC), .pcSel(pcSel), .jumpSel(jumpSel),
        .branchSel(branchSel), .regSel(regSel), .regJsel(regJsel), .selRj(selRj),
        .inSel(inSel), .selALU(selALU), .selDm(selDm), .regWrite(regWrite),
        .nop(nop), .memRead(memRead), .memWrite(memWrite), .ldWnd(ldWnd),
        .wndCtrl(wndCtrl), .funcCtrl(funcCtrl), .haltReq(haltReq), .stepReq(stepReq),
        .stepAck(stepAck), .halted(halted), .illegal(illegal), .retired(retired)
    );

    assign obsCtrl = {pcLd, rstPC, pcSel, jumpSel, branchSel, regSel, regJsel, selRj,
                      inSel, selALU, selDm, regWrite, nop, memRead, memWrite, ldWnd,
                      wndCtrl, funcCtrl};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               testsRun = 0;
    int               testsFailed = 0;
    int               bootLeft, cyc, lastAccept;
    bit               mHalted, prevStep, mIllegal;
    logic [CNT_W-1:0] mRetired;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic bit refIllegal(input logic [3:0] op, input logic [7:0] func);
        case (op)
            4'd3, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11: return 1'b1;
            4'd8: return !(func != 8'd0 && func < 8'h80 && (func & (func - 8'd1)) == 8'd0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t refDecode(input logic [3:0] op, input logic [7:0] func);
        ctrl_t c;
        int    k;
        c       = '0;
        c.pcLd  = 1'b1;
        c.pcSel = (op != 4'd2);
        c.nop   = !refIllegal(op, func);
        case (op)
            4'd0: begin c.memRead = 1'b1; c.selDm = 1'b1; c.regWrite = 1'b1; end
            4'd1: c.memWrite = 1'b1;
            4'd2: c.jumpSel = 1'b1;
            4'd4: begin c.branchSel = 1'b1; c.regSel = 1'b1; c.selRj = 1'b1; c.funcCtrl = 3'd1; end
            4'd8: if (!refIllegal(op, func)) begin
                k = 0;
                for (int i = 0; i < 7; i++)
                    if (func == (8'd1 << i)) k = i;
                if (k == 6) c.nop = 1'b0;
                else begin
                    c.selALU   = 1'b1;
                    c.regWrite = 1'b1;
                    if (k == 0) begin c.regJsel = 1'b1; c.funcCtrl = 3'd5; end
                    else if (k == 5) begin c.regJsel = 1'b1; c.funcCtrl = 3'd4; end
                    else begin c.regSel = 1'b1; c.selRj = 1'b1; c.funcCtrl = 3'(k - 1); end
                end
            end
            4'd9: begin c.ldWnd = 1'b1; c.wndCtrl = func[1:0]; end
            4'd12, 4'd13, 4'd14: begin
                c.regSel   = 1'b1;
                c.inSel    = 1'b1;
                c.selALU   = 1'b1;
                c.regWrite = 1'b1;
                c.funcCtrl = 3'(op - 4'd12);
            end
            default: ;
        endcase
        return c;
    endfunction

    // Called at a falling edge: drive, check this cycle, advance the model at the rising edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] func,
                                 input bit halt, input bit step);
        bit    booting, exec, accept, nextHalted;
        ctrl_t expCtrl;
        instIn  = op;
        funcIn  = func;
        haltReq = halt;
        stepReq = step;
        #1;
        booting = (bootLeft > 0);
        exec    = !booting && (!mHalted || cyc == lastAccept + 1);
        expCtrl = '0;
        if (booting) begin
            expCtrl.rstPC = 1'b1;
            expCtrl.pcLd  = 1'b1;
        end else if (exec) expCtrl = refDecode(op, func);
        checkOutput($sformatf("ctrl@%0d", cyc), 32'(obsCtrl), 32'(expCtrl));
        checkOutput($sformatf("halted@%0d", cyc), 32'(halted), 32'(mHalted));
        checkOutput($sformatf("stepAck@%0d", cyc), 32'(stepAck),
                    32'(STEP_EN && cyc == lastAccept + 2));
        checkOutput($sformatf("illegal@%0d", cyc), 32'(illegal), 32'(mIllegal));
        checkOutput($sformatf("retired@%0d", cyc), 32'(retired), 32'(mRetired));
        accept = STEP_EN && mHalted && halt && step && !prevStep && (cyc - lastAccept >= 3);
        if (booting) nextHalted = 1'b0;
        else if (STEP_EN) nextHalted = (exec && op == 4'd15) || halt;
        else nextHalted = (exec && op == 4'd15) || mHalted;
        @(posedge clk);
        if (booting) bootLeft--;
        if (exec) begin
            mRetired++;
            if (refIllegal(op, func)) mIllegal = 1'b1;
        end
        if (accept) lastAccept = cyc;
        mHalted  = nextHalted;
        prevStep = step;
        cyc++;
        @(negedge clk);
    endtask

    task automatic resetDut(input int n);
        ctrl_t r;
        r       = '0;
        r.pcLd  = 1'b1;
        r.rstPC = 1'b1;
        rst     = 1'b0;
        instIn  = 4'd0;
        funcIn  = 8'd0;
        haltReq = 1'b0;
        stepReq = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            checkOutput("resetCtrl", 32'(obsCtrl), 32'(r));
            checkOutput("resetFlags", 32'({halted, stepAck, illegal}), 32'd0);
            checkOutput("resetRetired", 32'(retired), 32'd0);
            @(negedge clk);
        end
        bootLeft   = BOOT_CYCLES;
        mHalted    = 1'b0;
        prevStep   = 1'b0;
        mIllegal   = 1'b0;
        mRetired   = '0;
        lastAccept = -100;
        cyc        = 0;
        rst        = 1'b1;
    endtask

    function automatic logic [7:0] randFunc();
        if ($urandom_range(0, 1) == 0) return 8'd1 << $urandom_range(0, 7);
        return 8'($urandom);
    endfunction

    initial begin
        logic [CNT_W-1:0] snap;
        int               ackCount;
        bit               stepPattern;
        rst     = 1'b0;
        instIn  = 4'd0;
        funcIn  = 8'd0;
        haltReq = 1'b0;
        stepReq = 1'b0;
        @(negedge clk);

        resetDut(3);
        for (int i = 0; i < BOOT_CYCLES; i++) applyStimulus(4'd0, 8'd0, 1'b0, 1'b0);
        applyStimulus(4'b1100, 8'h05, 1'b0, 1'b0);
        applyStimulus(4'b1000, 8'h06, 1'b0, 1'b0);
        applyStimulus(4'b1000, 8'h02, 1'b0, 1'b0);
        applyStimulus(4'b1000, 8'h40, 1'b0, 1'b0);

        resetDut(2);
        for (int i = 0; i < BOOT_CYCLES; i++) applyStimulus(4'd0, 8'd0, 1'b0, 1'b0);
        applyStimulus(4'b0011, 8'h00, 1'b0, 1'b0);
        applyStimulus(4'b0001, 8'h00, 1'b0, 1'b0);

        resetDut(2);
        for (int i = 0; i < 400; i++)
            applyStimulus(4'($urandom_range(0, 14)), randFunc(),
                          $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
        for (int i = 0; i < 3; i++) applyStimulus(4'b1100, 8'h01, 1'b0, 1'b0);

        if (STEP_EN) begin
            for (int i = 0; i < 3; i++) applyStimulus(4'b1000, 8'h02, 1'b1, 1'b0);
            snap     = mRetired;
            ackCount = 0;
            for (int i = 0; i < 14; i++) begin
                stepPattern = (i == 0) || (i == 4) || (i == 6);
                applyStimulus(4'b1000, 8'h02, 1'b1, stepPattern);
                if (stepAck) ackCount++;
            end
            checkOutput("stepRetired", 32'(retired), 32'(snap + CNT_W'(2)));
            checkOutput("stepAckCount", 32'(ackCount), 32'd2);
            for (int i = 0; i < 3; i++) applyStimulus(4'b1101, 8'h03, 1'b0, 1'b0);
        end

        snap = mRetired;
        applyStimulus(4'b1111, 8'h00, STEP_EN, 1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus(4'($urandom_range(0, 14)), randFunc(), STEP_EN, 1'b0);
        checkOutput("haltRetired", 32'(retired), 32'(snap + CNT_W'(1)));
        checkOutput("haltedFlag", 32'(halted), 32'd1);
        if (STEP_EN) for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0);
        else begin
            resetDut(2);
            for (int i = 0; i < BOOT_CYCLES + 2; i++) applyStimulus(4'b1110, 8'h0f, 1'b0, 1'b0);
        end

        instIn = 4'b0001;
        funcIn = 8'h00;
        #1;
        checkOutput("storeWrite", 32'(memWrite), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("storeAbortWrite", 32'(memWrite), 32'd0);
        checkOutput("storeAbortBoot", 32'(rstPC), 32'd1);
        @(negedge clk);
        resetDut(2);
        for (int i = 0; i < BOOT_CYCLES + 3; i++) applyStimulus(4'b0001, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
